// File: rtl/nexys_starship_spawn_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : nexys_starship_spawn_sched_if
//  Description : Signal bundle between the game controller / lane monster SMs
//                (master side) and the central spawn scheduler (slave side).
//                master drives timer_tick, play_flag, gameover_in, lane_full;
//                slave drives spawn_req, spawn_count, missed_grant and the
//                one-hot state flags q_Idle/q_Cool/q_Pick/q_Grant/q_Halt.
//  Revision    : 1.0  initial release
// ============================================================================
interface nexys_starship_spawn_sched_if;
    logic       timer_tick;
    logic       play_flag;
    logic       gameover_in;
    logic [3:0] lane_full;     // bit0 top, bit1 bottom, bit2 left, bit3 right
    logic [3:0] spawn_req;
    logic [7:0] spawn_count;
    logic       missed_grant;
    logic       q_Idle;
    logic       q_Cool;
    logic       q_Pick;
    logic       q_Grant;
    logic       q_Halt;

    modport master (
        output timer_tick, play_flag, gameover_in, lane_full,
        input  spawn_req, spawn_count, missed_grant,
               q_Idle, q_Cool, q_Pick, q_Grant, q_Halt
    );

    modport slave (
        input  timer_tick, play_flag, gameover_in, lane_full,
        output spawn_req, spawn_count, missed_grant,
               q_Idle, q_Cool, q_Pick, q_Grant, q_Halt
    );
endinterface
`default_nettype wire

// File: rtl/nexys_starship_spawn_sched.sv
`default_nettype none
// ============================================================================
//  Module      : nexys_starship_spawn_sched
//  Description : Central monster-spawn scheduler for the four lane monster
//                SMs. A free-running LFSR picks the lane, a cap on full lanes
//                throttles spawning, and each held request waits for the lane
//                to report full (or times out) before the next cooldown.
//  Ports       : Clk    - system clock
//                Reset  - synchronous active-high reset
//                bus    - slave modport of nexys_starship_spawn_sched_if
//                         (timer_tick, play_flag, gameover_in, lane_full in;
//                          spawn_req, spawn_count, missed_grant, q_* out)
//  Option      : SPAWN_SPEEDUP_EN - cooldown shortens by one tick after every
//                8th acknowledged spawn, floored at 1.
//  Revision    : 1.0  initial release
// ============================================================================
module nexys_starship_spawn_sched #(
    parameter int         MAX_ACTIVE     = 2,
    parameter int         COOLDOWN_TICKS = 3,
    parameter int         GRANT_TIMEOUT  = 4,
    parameter logic [7:0] LFSR_SEED      = 8'h01
) (
    input  logic                                Clk,
    input  logic                                Reset,
    nexys_starship_spawn_sched_if.slave         bus
);

    localparam logic [7:0] c_CD_LIM  = (COOLDOWN_TICKS < 1) ? 8'd1 : 8'(COOLDOWN_TICKS);
    localparam logic [7:0] c_TO_LIM  = (GRANT_TIMEOUT  < 1) ? 8'd1 : 8'(GRANT_TIMEOUT);
    localparam logic [2:0] c_MAX_ACT = 3'(MAX_ACTIVE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COOL  = 3'd1,
        S_PICK  = 3'd2,
        S_GRANT = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t     r_state,       w_state_nx;
    logic [7:0] r_lfsr;
    logic [3:0] r_spawn_req,   w_spawn_req_nx;
    logic [7:0] r_spawn_count, w_spawn_count_nx;
    logic       r_missed,      w_missed_nx;
    logic [7:0] r_cd_cnt,      w_cd_cnt_nx;
    logic [7:0] r_to_cnt,      w_to_cnt_nx;
    logic [7:0] w_cd_lim;

    logic [2:0] w_active;
    logic [1:0] w_sel;
    logic       w_sel_vld;
    logic [1:0] w_idx;
    logic       w_ack;
    logic [7:0] w_cnt_inc;
    logic       w_cnt_wrap8;

    // ------------------------------------------------------------------
    // Cooldown limit: constant, or a register that shrinks with progress
    // ------------------------------------------------------------------
`ifdef SPAWN_SPEEDUP_EN
    logic [7:0] r_cd_lim, w_cd_lim_nx;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cd_lim <= c_CD_LIM;
        end else begin
            r_cd_lim <= w_cd_lim_nx;
        end
    end

    always_comb begin
        w_cd_lim_nx = r_cd_lim;
        if (r_state == S_IDLE && bus.play_flag) begin
            w_cd_lim_nx = c_CD_LIM;
        end else if (r_state == S_GRANT && !bus.gameover_in && w_ack &&
                     w_cnt_wrap8 && r_cd_lim > 8'd1) begin
            w_cd_lim_nx = r_cd_lim - 8'd1;
        end
    end

    assign w_cd_lim = r_cd_lim;
`else
    assign w_cd_lim = c_CD_LIM;
`endif

    // ------------------------------------------------------------------
    // LFSR runs every cycle regardless of state
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    // ------------------------------------------------------------------
    // Lane selection helpers
    // ------------------------------------------------------------------
    assign w_active = 3'(bus.lane_full[0]) + 3'(bus.lane_full[1]) +
                      3'(bus.lane_full[2]) + 3'(bus.lane_full[3]);

    // Walk the rotation from the highest offset down so the lowest offset
    // from the LFSR base that is empty is the one left in w_sel.
    always_comb begin
        w_sel     = 2'd0;
        w_sel_vld = 1'b0;
        w_idx     = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            w_idx = r_lfsr[1:0] + 2'(k);
            if (!bus.lane_full[w_idx]) begin
                w_sel     = w_idx;
                w_sel_vld = 1'b1;
            end
        end
    end

    // The request is one-hot, so the addressed lane reporting full is simply
    // any overlap between the request and lane_full.
    assign w_ack       = |(bus.lane_full & r_spawn_req);
    assign w_cnt_inc   = (r_spawn_count == 8'hFF) ? 8'hFF : r_spawn_count + 8'd1;
    assign w_cnt_wrap8 = (r_spawn_count != 8'hFF) && (w_cnt_inc[2:0] == 3'd0);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_spawn_req   <= 4'd0;
            r_spawn_count <= 8'd0;
            r_missed      <= 1'b0;
            r_cd_cnt      <= 8'd0;
            r_to_cnt      <= 8'd0;
        end else begin
            r_state       <= w_state_nx;
            r_spawn_req   <= w_spawn_req_nx;
            r_spawn_count <= w_spawn_count_nx;
            r_missed      <= w_missed_nx;
            r_cd_cnt      <= w_cd_cnt_nx;
            r_to_cnt      <= w_to_cnt_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nx       = r_state;
        w_spawn_req_nx   = r_spawn_req;
        w_spawn_count_nx = r_spawn_count;
        w_missed_nx      = r_missed;
        w_cd_cnt_nx      = r_cd_cnt;
        w_to_cnt_nx      = r_to_cnt;

        case (r_state)
            S_IDLE: begin
                // Outputs stay at their reset values while idle.
                w_spawn_req_nx   = 4'd0;
                w_spawn_count_nx = 8'd0;
                w_missed_nx      = 1'b0;
                w_cd_cnt_nx      = 8'd0;
                w_to_cnt_nx      = 8'd0;
                if (bus.play_flag) begin
                    w_state_nx = S_COOL;
                end
            end

            S_COOL: begin
                if (bus.gameover_in) begin
                    w_state_nx     = S_HALT;
                    w_spawn_req_nx = 4'd0;
                end else if (bus.timer_tick) begin
                    w_cd_cnt_nx = r_cd_cnt + 8'd1;
                    if (r_cd_cnt >= w_cd_lim - 8'd1) begin
                        w_state_nx = S_PICK;
                    end
                end
            end

            S_PICK: begin
                if (bus.gameover_in) begin
                    w_state_nx     = S_HALT;
                    w_spawn_req_nx = 4'd0;
                end else if (w_active < c_MAX_ACT && w_sel_vld) begin
                    w_spawn_req_nx = 4'b0001 << w_sel;
                    w_to_cnt_nx    = 8'd0;
                    w_state_nx     = S_GRANT;
                end
            end

            S_GRANT: begin
                if (bus.gameover_in) begin
                    w_state_nx     = S_HALT;
                    w_spawn_req_nx = 4'd0;
                end else if (w_ack) begin
                    // Ack has priority over a timeout on the same tick.
                    w_spawn_req_nx   = 4'd0;
                    w_spawn_count_nx = w_cnt_inc;
                    w_cd_cnt_nx      = 8'd0;
                    w_state_nx       = S_COOL;
                end else if (bus.timer_tick) begin
                    if (r_to_cnt >= c_TO_LIM - 8'd1) begin
                        w_spawn_req_nx = 4'd0;
                        w_missed_nx    = 1'b1;
                        w_cd_cnt_nx    = 8'd0;
                        w_state_nx     = S_COOL;
                    end else begin
                        w_to_cnt_nx = r_to_cnt + 8'd1;
                    end
                end
            end

            S_HALT: begin
                w_spawn_req_nx = 4'd0;
                if (!bus.play_flag) begin
                    // Leaving for IDLE clears everything so IDLE shows reset values.
                    w_state_nx       = S_IDLE;
                    w_spawn_count_nx = 8'd0;
                    w_missed_nx      = 1'b0;
                    w_cd_cnt_nx      = 8'd0;
                    w_to_cnt_nx      = 8'd0;
                end
            end

            default: begin
                w_state_nx     = S_IDLE;
                w_spawn_req_nx = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.spawn_req    = r_spawn_req;
    assign bus.spawn_count  = r_spawn_count;
    assign bus.missed_grant = r_missed;
    assign bus.q_Idle       = (r_state == S_IDLE);
    assign bus.q_Cool       = (r_state == S_COOL);
    assign bus.q_Pick       = (r_state == S_PICK);
    assign bus.q_Grant      = (r_state == S_GRANT);
    assign bus.q_Halt       = (r_state == S_HALT);

endmodule
`default_nettype wire
